id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: ID_EX_STAGE

Interface
REQ-001 Parameters SHALL be: WIDTH, 32, datapath width; ADD_WIDTH, 5, register address width; CTRL_WIDTH, 8, control bundle width.
REQ-002 The block SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-003 CLK  in  1  rising-edge clock of the system.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 ID_VALID  in  1  the decode slot holds a real instruction.
REQ-006 ID_PC  in  WIDTH  PC of the decoded instruction.
REQ-007 ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR  in  ADD_WIDTH each  source and destination register addresses.
REQ-008 ID_USES_RS1, ID_USES_RS2  in  1 each  the instruction actually reads rs1/rs2.
REQ-009 ID_READ_DATA_1, ID_READ_DATA_2  in  WIDTH each  register file read ports; these already include same-cycle writeback bypass.
REQ-010 ID_IMM  in  WIDTH  sign-extended immediate.
REQ-011 ID_CTRL  in  CTRL_WIDTH  decoded controls; bit MEM_READ marks a load, bit REG_WRITE marks a register write.
REQ-012 FLUSH  in  1  branch or jump resolved taken in EX; kill the decode slot.
REQ-013 HOLD  in  1  downstream not ready; freeze the EX register.
REQ-014 EX_VALID, EX_PC, EX_RS1_ADDR, EX_RS2_ADDR, EX_RD_ADDR, EX_OP_A, EX_OP_B, EX_IMM, EX_CTRL  out  widths as the matching inputs  registered EX-stage copies.
REQ-015 STALL  out  1  combinational; tells IF/ID to hold PC and instruction.
REQ-016 STALL_COUNT  out  16  number of load-use bubbles inserted.

Function
REQ-017 Load-use hazard (LU) SHALL be: ID_VALID & EX_VALID & EX_CTRL[MEM_READ] & EX_RD_ADDR!=0 & ((ID_USES_RS1 & ID_RS1_ADDR==EX_RD_ADDR) | (ID_USES_RS2 & ID_RS2_ADDR==EX_RD_ADDR)).
REQ-018 STALL SHALL equal (LU | HOLD) & ~FLUSH.
REQ-019 Each rising edge SHALL apply this priority order:
- RESET → clear.
- FLUSH → bubble.
- HOLD → retain all EX registers.
- LU → bubble.
- otherwise → capture all ID_* inputs into EX_*; READ_DATA_1/2 go to OP_A/OP_B.
REQ-020 A bubble SHALL set EX_VALID=0 and EX_CTRL=0; the other EX fields are don't-care but SHALL be zeroed.
REQ-021 Capture SHALL force EX_CTRL=0 when ID_VALID=0, so no write or memory side effect is possible.
REQ-022 A load-use stall SHALL last exactly one cycle: the inserted bubble clears EX_CTRL[MEM_READ], so LU deasserts on the next cycle.
REQ-023 A hazard on rd=x0 SHALL never stall, and a hazard on a source that is not used SHALL never stall.
REQ-024 FLUSH coincident with LU SHALL insert one bubble, keep STALL=0, and leave STALL_COUNT unchanged.
REQ-025 HOLD coincident with LU SHALL retain the EX registers, keep STALL=1, and leave STALL_COUNT unchanged; LU is re-evaluated after HOLD drops.
REQ-026 STALL_COUNT SHALL increment by 1 only on an edge where an LU bubble is inserted, and SHALL saturate at 16'hFFFF.
REQ-027 Latency ID→EX SHALL be one cycle; the block SHALL have no other state.

Reset
REQ-028 While RESET=1 at an edge: EX_VALID=0, EX_CTRL=0, all other EX_* =0, STALL_COUNT=0.
REQ-029 STALL SHALL be 0 while the EX register holds its reset value.
REQ-030 RESET asserted mid-stall or mid-hold SHALL discard the in-flight instruction, with no replay.

Structure
REQ-031 A shared package SHALL hold: CTRL_WIDTH, the control bit indices (MEM_READ, REG_WRITE, MEM_WRITE, ALU_SRC, MEM_TO_REG, ALU_OP field), and the BUBBLE_CTRL constant (all zeros).
REQ-032 Load-use comparison SHALL be one combinational sub-module, HAZARD_DETECT, so that the forwarding unit can reuse it.

Verification
REQ-033 Scenario: lw x5 in EX, ID add x6,x5,x7 with USES_RS1=1 → STALL=1 for one cycle, next EX_VALID=0, the cycle after that EX captures add with OP_A as supplied, STALL_COUNT=1.
REQ-034 Scenario: lw x0 in EX, ID reads x0 → STALL=0, no bubble, STALL_COUNT=0.
REQ-035 Scenario: lw x5 in EX, ID addi x6,x8,4 with USES_RS2=0 and RS2_ADDR=5 → STALL=0, addi captured next cycle.
REQ-036 Scenario: FLUSH=1 with LU true → STALL=0, next EX_VALID=0 and EX_CTRL=0, STALL_COUNT unchanged.
REQ-037 Scenario: HOLD=1 for 3 cycles with EX_PC=0x40 → EX_PC stays 0x40 and STALL=1 throughout; on release the next ID instruction is captured.
REQ-038 Scenario: preload STALL_COUNT to 0xFFFE, then force 3 LU bubbles → count reads 0xFFFF and holds; RESET during an LU → all EX_* =0 and count=0 on the next edge.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: control-bundle layout and widths shared by the ID/EX register and hazard logic.
package id_ex_stage_pkg;
    localparam int CTRL_WIDTH = 8;
    localparam int MEM_READ = 0;
    localparam int REG_WRITE = 1;
    localparam int MEM_WRITE = 2;
    localparam int ALU_SRC = 3;
    localparam int MEM_TO_REG = 4;
    localparam int ALU_OP_LSB = 5;
    localparam int ALU_OP_MSB = 7;
    localparam logic [CTRL_WIDTH-1:0] BUBBLE_CTRL = '0;
endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: load-use comparison between the decode slot and the load sitting in EX.
module hazard_detect #(
    parameter int ADD_WIDTH = 5
) (
    input  logic                 ID_VALID,
    input  logic                 EX_VALID,
    input  logic                 EX_MEM_READ,
    input  logic [ADD_WIDTH-1:0] EX_RD_ADDR,
    input  logic [ADD_WIDTH-1:0] ID_RS1_ADDR,
    input  logic [ADD_WIDTH-1:0] ID_RS2_ADDR,
    input  logic                 ID_USES_RS1,
    input  logic                 ID_USES_RS2,
    output logic                 LOAD_USE
);
    assign LOAD_USE = ID_VALID & EX_VALID & EX_MEM_READ & (EX_RD_ADDR != '0) &
                      ((ID_USES_RS1 & (ID_RS1_ADDR == EX_RD_ADDR)) |
                       (ID_USES_RS2 & (ID_RS2_ADDR == EX_RD_ADDR)));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with flush, hold and one-cycle load-use bubble insertion.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ADD_WIDTH = 5,
    parameter int CTRL_WIDTH = id_ex_stage_pkg::CTRL_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ID_VALID,
    input  logic [WIDTH-1:0]      ID_PC,
    input  logic [ADD_WIDTH-1:0]  ID_RS1_ADDR,
    input  logic [ADD_WIDTH-1:0]  ID_RS2_ADDR,
    input  logic [ADD_WIDTH-1:0]  ID_RD_ADDR,
    input  logic                  ID_USES_RS1,
    input  logic                  ID_USES_RS2,
    input  logic [WIDTH-1:0]      ID_READ_DATA_1,
    input  logic [WIDTH-1:0]      ID_READ_DATA_2,
    input  logic [WIDTH-1:0]      ID_IMM,
    input  logic [CTRL_WIDTH-1:0] ID_CTRL,
    input  logic                  FLUSH,
    input  logic                  HOLD,
    output logic                  EX_VALID,
    output logic [WIDTH-1:0]      EX_PC,
    output logic [ADD_WIDTH-1:0]  EX_RS1_ADDR,
    output logic [ADD_WIDTH-1:0]  EX_RS2_ADDR,
    output logic [ADD_WIDTH-1:0]  EX_RD_ADDR,
    output logic [WIDTH-1:0]      EX_OP_A,
    output logic [WIDTH-1:0]      EX_OP_B,
    output logic [WIDTH-1:0]      EX_IMM,
    output logic [CTRL_WIDTH-1:0] EX_CTRL,
    output logic                  STALL,
    output logic [15:0]           STALL_COUNT
);
    logic lu, bubble, lu_bubble;
    logic [15:0] stall_cnt;

    hazard_detect #(.ADD_WIDTH(ADD_WIDTH)) u_hazard (
        .ID_VALID    (ID_VALID),
        .EX_VALID    (EX_VALID),
        .EX_MEM_READ (EX_CTRL[MEM_READ]),
        .EX_RD_ADDR  (EX_RD_ADDR),
        .ID_RS1_ADDR (ID_RS1_ADDR),
        .ID_RS2_ADDR (ID_RS2_ADDR),
        .ID_USES_RS1 (ID_USES_RS1),
        .ID_USES_RS2 (ID_USES_RS2),
        .LOAD_USE    (lu)
    );

    // FLUSH outranks HOLD, HOLD outranks the load-use bubble
    assign lu_bubble = lu & ~HOLD & ~FLUSH;
    assign bubble = FLUSH | lu_bubble;
    assign STALL = (lu | HOLD) & ~FLUSH;
    assign STALL_COUNT = stall_cnt;

    always_ff @(posedge CLK) begin
        if (RESET || bubble) begin
            EX_VALID <= 1'b0;
            EX_PC <= '0;
            EX_RS1_ADDR <= '0;
            EX_RS2_ADDR <= '0;
            EX_RD_ADDR <= '0;
            EX_OP_A <= '0;
            EX_OP_B <= '0;
            EX_IMM <= '0;
            EX_CTRL <= CTRL_WIDTH'(BUBBLE_CTRL);
        end else if (!HOLD) begin
            EX_VALID <= ID_VALID;
            EX_PC <= ID_PC;
            EX_RS1_ADDR <= ID_RS1_ADDR;
            EX_RS2_ADDR <= ID_RS2_ADDR;
            EX_RD_ADDR <= ID_RD_ADDR;
            EX_OP_A <= ID_READ_DATA_1;
            EX_OP_B <= ID_READ_DATA_2;
            EX_IMM <= ID_IMM;
            EX_CTRL <= ID_VALID ? ID_CTRL : CTRL_WIDTH'(BUBBLE_CTRL);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            stall_cnt <= '0;
        else if (lu_bubble && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
endmodule
